systolic_edge_feeder: RTL and testbench
=======================================

// Module: systolic_edge_feeder
// PURPOSE
//  Upstream stage of the shift-MAC systolic array. Accepts one k-slice per beat
//  (N activation bytes for the left edge, N weight codes for the top edge) and
//  applies a triangular skew so that operands with the same k meet at PE(i,j).
//  Idle and flush cycles drive zeros, so the PEs accumulate +0.
//  Sequences each tile IDLE->STREAM->FLUSH and flags completion once the array
//  has fully absorbed the tile.
// PARAMETERS
//  N    4  array dimension (rows = cols = lanes per edge), N>=2
//  DW   8  lane width in bits. Top-edge lanes carry {sign, ..., shift[3:0]}.
//  CW   8  width of the flush counter; must hold 3*(N-1)+1
// PORTS
//  clk        in   1     clock, rising edge
//  reset      in   1     asynchronous, active-high
//  s_valid    in   1     input beat valid
//  s_ready    out  1     feeder can accept a beat
//  s_last     in   1     beat is the final k-slice of the tile
//  s_left     in   N*DW  activations; lane i = bits [i*DW +: DW], goes to row i
//  s_up       in   N*DW  weight codes; lane j = bits [j*DW +: DW], goes to col j
//  left_edge  out  N*DW  to the left_in of row i, PE(i,0)
//  up_edge    out  N*DW  to the up_in of column j, PE(0,j)
//  busy       out  1     high in STREAM or FLUSH
//  tile_done  out  1     one-cycle pulse when the tile is fully absorbed
// BEHAVIOUR
//  - Reset: all skew registers, left_edge, up_edge, busy, tile_done and the
//    counter clear to 0. FSM goes to IDLE. s_ready is 1 right after reset.
//  - Reset mid-tile: the tile is discarded with no tile_done. The array is reset
//    by the same signal.
//  - Handshake: a beat transfers when s_valid & s_ready. s_ready = (state != FLUSH).
//    Data must stay stable while s_valid is high and s_ready is low.
//  - Lane skew:
//    - Lane i of s_left is registered (1+i) times before reaching left_edge lane i.
//    - Lane j of s_up is registered (1+j) times before reaching up_edge lane j.
//    - Lane 0 latency is 1 cycle. Lane N-1 latency is N cycles.
//    - Skew chains shift every cycle; there is no back-pressure inside the chains.
//  - Bubbles: in a cycle with no transfer, the chain heads load 0 on both edges,
//    so row/column alignment is preserved.
//  - FSM:
//    - IDLE: on a transfer go to STREAM. If s_last is set on that same beat,
//      go straight to FLUSH.
//    - STREAM: on a transfer with s_last go to FLUSH and set cnt = 0.
//    - FLUSH: s_ready = 0 and the chains fill with 0. cnt increments every cycle.
//      When cnt == 3*(N-1), assert tile_done for 1 cycle and go to IDLE.
//    - FLUSH length covers skew (N-1), horizontal pass (N-1), vertical pass (N-1)
//      and the PE output register (1).
//  - busy = (state != IDLE). It falls in the same cycle tile_done is high.
//  - Back-to-back tiles: a new beat is accepted in the cycle after tile_done.
//  - No arithmetic is done here; lanes are passed through bit-exact.
// CONFIGURATION
//  FEEDER_STATS_EN
//  - Defined: adds output beat_cnt [15:0] and output stall_cnt [15:0].
//    - beat_cnt counts accepted beats in the current tile.
//    - stall_cnt counts STREAM cycles with s_valid=0.
//    - Both clear on reset and on entry to STREAM.
//    - Both saturate at 16'hFFFF and hold their value through FLUSH and IDLE.
//  - Not defined: these ports and registers do not exist. Behaviour is otherwise
//    identical.
// TESTING
//  1 Reset: hold reset=1 mid-stream -> all outputs 0, busy=0, s_ready=1;
//    no tile_done after release.
//  2 Skew, N=4: single beat s_left=32'h04030201, s_up=0, s_last=1 at cycle t
//    -> left_edge lane0=01 at t+1, lane1=02 at t+2, lane2=03 at t+3,
//    lane3=04 at t+4; all other cycles 0.
//  3 Tile timing: 4 consecutive beats, last at t -> s_ready=0 from t+1;
//    tile_done at t+10; busy low at t+10; s_ready=1 at t+10.
//  4 Bubble: beats k0, idle, k1, all lanes = 8'h11 -> each lane shows 11,00,11
//    on both edges with identical per-lane offsets.
//  5 End to end, with the 4x4 MAC array: A = all 1s; B codes with shift
//    0/1/2/3 per column; 4 beats -> after tile_done, column j of mat_out
//    = 4<<j, i.e. 4,8,16,32.
//  6 FEEDER_STATS_EN: 5 beats with 2 stall cycles -> beat_cnt=5, stall_cnt=2 at
//    tile_done; without the macro the bench compiles without these ports.

Source files
------------

// File: rtl/systolic_edge_feeder_if.sv
// systolic_edge_feeder_if
//  Beat stream carrying one k-slice of the tile into the edge feeder.
//  s_valid  producer -> feeder   beat valid
//  s_ready  feeder -> producer   feeder can accept a beat
//  s_last   producer -> feeder   final k-slice of the tile
//  s_left   producer -> feeder   N activation lanes, lane i at [i*DW +: DW]
//  s_up     producer -> feeder   N weight-code lanes, lane j at [j*DW +: DW]
interface systolic_edge_feeder_if #(
   parameter int N  = 4,
   parameter int DW = 8
);
   logic            s_valid;
   logic            s_ready;
   logic            s_last;
   logic [N*DW-1:0] s_left;
   logic [N*DW-1:0] s_up;

   modport master (output s_valid, s_last, s_left, s_up, input s_ready);
   modport slave  (input s_valid, s_last, s_left, s_up, output s_ready);
endinterface

// File: rtl/systolic_edge_feeder.sv
// systolic_edge_feeder
//  Upstream stage of the shift-MAC systolic array. Each accepted beat carries
//  one k-slice: N activation lanes for the left edge and N weight codes for the
//  top edge. Lane i is delayed by 1+i registers so equal-k operands meet at
//  PE(i,j). Cycles without a transfer inject zeros. Each tile runs
//  IDLE -> STREAM -> FLUSH and tile_done pulses once the array has absorbed it.
//  Ports:
//   clk, reset  clock (rising edge), asynchronous active-high reset
//   s           slave side of systolic_edge_feeder_if (beat stream)
//   left_edge   N*DW, lane i drives left_in of PE(i,0)
//   up_edge     N*DW, lane j drives up_in of PE(0,j)
//   busy        high while in STREAM or FLUSH
//   tile_done   one-cycle pulse at tile completion
//   beat_cnt, stall_cnt  16-bit statistics, only when FEEDER_STATS_EN is defined
//  Optional feature macro: FEEDER_STATS_EN
module systolic_edge_feeder #(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int CW = 8
) (
   input  logic            clk,
   input  logic            reset,
   systolic_edge_feeder_if.slave s,
   output logic [N*DW-1:0] left_edge,
   output logic [N*DW-1:0] up_edge,
   output logic            busy,
   output logic            tile_done
`ifdef FEEDER_STATS_EN
   ,
   output logic [15:0]     beat_cnt,
   output logic [15:0]     stall_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

   // Flush spans skew, horizontal pass, vertical pass and PE output register.
   localparam logic [CW-1:0] FLUSH_LAST = CW'(3 * (N - 1));

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
   logic            tile_done_q, tile_done_d;
   logic            xfer;

   assign s.s_ready = (state_q != FLUSH);
   assign xfer      = s.s_valid & s.s_ready;
   assign busy      = (state_q != IDLE);
   assign tile_done = tile_done_q;
   assign cnt_inc   = cnt_q + 1'b1;

   // Per-lane skew chains; lane i has 1+i stages, the last stage is the edge.
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [DW-1:0] l_q [0:i];
      logic [DW-1:0] l_d [0:i];
      logic [DW-1:0] u_q [0:i];
      logic [DW-1:0] u_d [0:i];

      always_comb begin
         // Heads load zero on bubbles so row/column alignment is kept.
         l_d[0] = xfer ? s.s_left[i*DW +: DW] : '0;
         u_d[0] = xfer ? s.s_up[i*DW +: DW]   : '0;
         for (int k = 1; k <= i; k++) begin
            l_d[k] = l_q[k-1];
            u_d[k] = u_q[k-1];
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int k = 0; k <= i; k++) begin
               l_q[k] <= '0;
               u_q[k] <= '0;
            end
         end else begin
            l_q <= l_d;
            u_q <= u_d;
         end
      end

      assign left_edge[i*DW +: DW] = l_q[i];
      assign up_edge[i*DW +: DW]   = u_q[i];
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tile_done_d = 1'b0;
      case (state_q)
         IDLE: if (xfer) begin
            state_d = s.s_last ? FLUSH : STREAM;
            cnt_d   = '0;
         end
         STREAM: if (xfer && s.s_last) begin
            state_d = FLUSH;
            cnt_d   = '0;
         end
         FLUSH: begin
            // Compare the value being written so tile_done and IDLE land together.
            cnt_d = cnt_inc;
            if (cnt_inc == FLUSH_LAST) begin
               state_d     = IDLE;
               tile_done_d = 1'b1;
               cnt_d       = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         tile_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tile_done_q <= tile_done_d;
      end
   end

`ifdef FEEDER_STATS_EN
   logic [15:0] beat_q, beat_d, stall_q, stall_d;

   always_comb begin
      beat_d  = beat_q;
      stall_d = stall_q;
      if (state_q == IDLE && xfer) begin
         // First beat of a tile restarts both counters.
         beat_d  = 16'd1;
         stall_d = '0;
      end else if (state_q == STREAM) begin
         if (xfer && beat_q != 16'hFFFF)
            beat_d = beat_q + 16'd1;
         if (!s.s_valid && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         beat_q  <= '0;
         stall_q <= '0;
      end else begin
         beat_q  <= beat_d;
         stall_q <= stall_d;
      end
   end

   assign beat_cnt  = beat_q;
   assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_systolic_edge_feeder.sv
module tb_systolic_edge_feeder;
   localparam int N  = 4;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic reset;
   logic [N*DW-1:0] left_edge, up_edge;
   logic busy, tile_done;
`ifdef FEEDER_STATS_EN
   logic [15:0] beat_cnt, stall_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic        stim_v    [0:31];
   logic        stim_last [0:31];
   logic [31:0] stim_l    [0:31];
   logic [31:0] stim_u    [0:31];

   systolic_edge_feeder_if #(.N(N), .DW(DW)) bus ();

   systolic_edge_feeder #(.N(N), .DW(DW), .CW(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .s         (bus.slave),
      .left_edge (left_edge),
      .up_edge   (up_edge),
      .busy      (busy),
      .tile_done (tile_done)
`ifdef FEEDER_STATS_EN
      ,
      .beat_cnt  (beat_cnt),
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stim();
      for (int c = 0; c < 32; c++) begin
         stim_v[c] = 1'b0; stim_last[c] = 1'b0; stim_l[c] = '0; stim_u[c] = '0;
      end
   endtask

   task automatic idle_inputs();
      bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_left = '0; bus.s_up = '0;
   endtask

   // Drives stim_* at cycles 0..ncyc and checks every following cycle.
   // Beats are only scheduled before the tile's last beat, where s_ready is
   // high, so each scheduled beat is a transfer. Lane i shows the beat from
   // cycle c-1-i at cycle c.
   task automatic run(input int ncyc, input int tfirst, input int tlast,
                      input int tdone, input int eb, input int es);
      logic [31:0] in_l [0:31];
      logic [31:0] in_u [0:31];
      logic [31:0] exp_l, exp_u;
      int c, idx;
      for (int r = 0; r < 32; r++) begin in_l[r] = '0; in_u[r] = '0; end
      for (int r = 0; r <= ncyc; r++) begin
         bus.s_valid = stim_v[r];
         bus.s_last  = stim_last[r];
         bus.s_left  = stim_l[r];
         bus.s_up    = stim_u[r];
         in_l[r] = stim_v[r] ? stim_l[r] : '0;
         in_u[r] = stim_v[r] ? stim_u[r] : '0;
         step();
         c = r + 1;
         exp_l = '0; exp_u = '0;
         for (int i = 0; i < N; i++) begin
            idx = c - 1 - i;
            if (idx >= 0) begin
               exp_l[i*DW +: DW] = in_l[idx][i*DW +: DW];
               exp_u[i*DW +: DW] = in_u[idx][i*DW +: DW];
            end
         end
         check($sformatf("left_edge c%0d", c), left_edge, exp_l);
         check($sformatf("up_edge c%0d", c), up_edge, exp_u);
         check($sformatf("tile_done c%0d", c), {31'd0, tile_done}, {31'd0, c == tdone});
         check($sformatf("busy c%0d", c), {31'd0, busy}, {31'd0, c > tfirst && c < tdone});
         check($sformatf("s_ready c%0d", c), {31'd0, bus.s_ready},
               {31'd0, !(c > tlast && c < tdone)});
`ifdef FEEDER_STATS_EN
         if (c == tdone && eb >= 0) begin
            check("beat_cnt", {16'd0, beat_cnt}, eb[31:0]);
            check("stall_cnt", {16'd0, stall_cnt}, es[31:0]);
         end
`endif
      end
      idle_inputs();
      step();
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      clear_stim();
      step();
      step();
      // Reset state
      check("rst left_edge", left_edge, 32'h0);
      check("rst up_edge", up_edge, 32'h0);
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst tile_done", {31'd0, tile_done}, 32'd0);
      check("rst s_ready", {31'd0, bus.s_ready}, 32'd1);
      reset = 1'b0;
      step();

      // Reset mid-stream: two beats in, then reset while streaming
      bus.s_valid = 1'b1; bus.s_left = 32'h11223344; bus.s_up = 32'h55667788;
      step();
      step();
      idle_inputs();
      check("mid busy", {31'd0, busy}, 32'd1);
      check("mid left_edge", left_edge, 32'h00003344);
      check("mid up_edge", up_edge, 32'h00007788);
      #1 reset = 1'b1;
      #1;
      check("arst left_edge", left_edge, 32'h0);
      check("arst up_edge", up_edge, 32'h0);
      check("arst busy", {31'd0, busy}, 32'd0);
      check("arst s_ready", {31'd0, bus.s_ready}, 32'd1);
      step();
      reset = 1'b0;
      for (int c = 0; c < 12; c++) begin
         step();
         check($sformatf("post-rst tile_done c%0d", c), {31'd0, tile_done}, 32'd0);
         check($sformatf("post-rst busy c%0d", c), {31'd0, busy}, 32'd0);
      end

      // Skew: single last beat at cycle 0
      clear_stim();
      stim_v[0] = 1'b1; stim_last[0] = 1'b1; stim_l[0] = 32'h04030201;
      run(11, 0, 0, 10, -1, -1);

      // Tile timing: four consecutive beats, distinct per-lane data on both edges
      clear_stim();
      for (int k = 0; k < 4; k++) begin
         stim_v[k] = 1'b1;
         stim_l[k] = 32'hA3A2A1A0 + 32'h10101010 * k;
         stim_u[k] = 32'hB3B2B1B0 + 32'h04040404 * k;
      end
      stim_last[3] = 1'b1;
      run(14, 0, 3, 13, 4, 0);

      // Bubble: k0, idle, k1 with all lanes 8'h11
      clear_stim();
      stim_v[0] = 1'b1; stim_l[0] = 32'h11111111; stim_u[0] = 32'h11111111;
      stim_v[2] = 1'b1; stim_l[2] = 32'h11111111; stim_u[2] = 32'h11111111;
      stim_last[2] = 1'b1;
      run(13, 0, 2, 12, 2, 1);

      // Five beats with two stall cycles
      clear_stim();
      foreach (stim_v[c]) if (c == 0 || c == 1 || c == 3 || c == 5 || c == 6) begin
         stim_v[c] = 1'b1;
         stim_l[c] = 32'h01020304 + 32'h01010101 * c;
         stim_u[c] = 32'h0F0E0D0C - 32'h01010101 * c;
      end
      stim_last[6] = 1'b1;
      run(17, 0, 6, 16, 5, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
